// File: rtl/pwm_burst_gen.sv
// Programmable PWM / clock-pulse generator with continuous and burst modes.
// Period and high time are shadowed and only reloaded at period boundaries.
module pwm_burst_gen #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned BURST_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [CNT_W-1:0]   cfg_period,
  input  logic [CNT_W-1:0]   cfg_high,
  input  logic [BURST_W-1:0] cfg_bursts,
  output logic               sig,
  output logic [CNT_W-1:0]   count,
  output logic               tick,
  output logic               busy,
  output logic               done,
  output logic [BURST_W-1:0] burst_left
);

  typedef enum logic [0:0] {StIdle, StRun} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   per_q, per_d;
  logic [CNT_W-1:0]   high_q, high_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic               mode_q, mode_d;
  logic               stop_pend_q, stop_pend_d;
  logic               sig_q, sig_d;
  logic               tick_q, tick_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // One extra bit so count+1 never wraps before the high-time compare.
  logic [CNT_W:0] count_inc;
  assign count_inc = {1'b0, count_q} + {{CNT_W{1'b0}}, 1'b1};

  logic start_ok;
  assign start_ok = start && !(mode && (cfg_bursts == '0));

  logic last_period;
  assign last_period = (mode_q && (burst_q == BURST_W'(1))) || stop_pend_q;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    per_d       = per_q;
    high_d      = high_q;
    burst_d     = burst_q;
    mode_d      = mode_q;
    stop_pend_d = stop_pend_q;
    sig_d       = sig_q;
    tick_d      = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        count_d     = '0;
        sig_d       = 1'b0;
        busy_d      = 1'b0;
        burst_d     = '0;
        stop_pend_d = 1'b0;
        if (start_ok) begin
          per_d   = cfg_period;
          high_d  = cfg_high;
          mode_d  = mode;
          burst_d = mode ? cfg_bursts : '0;
          sig_d   = (cfg_high != '0);
          tick_d  = 1'b1;
          busy_d  = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        if (stop) stop_pend_d = 1'b1;
        if (en) begin
          if (count_q != per_q) begin
            count_d = count_q + CNT_W'(1);
            sig_d   = (count_inc < {1'b0, high_q});
          end else if (last_period) begin
            state_d     = StIdle;
            count_d     = '0;
            sig_d       = 1'b0;
            busy_d      = 1'b0;
            burst_d     = '0;
            done_d      = 1'b1;
            stop_pend_d = 1'b0;
          end else begin
            per_d   = cfg_period;
            high_d  = cfg_high;
            count_d = '0;
            sig_d   = (cfg_high != '0);
            tick_d  = 1'b1;
            if (mode_q) burst_d = burst_q - BURST_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      count_q     <= '0;
      per_q       <= '0;
      high_q      <= '0;
      burst_q     <= '0;
      mode_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      sig_q       <= 1'b0;
      tick_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      per_q       <= per_d;
      high_q      <= high_d;
      burst_q     <= burst_d;
      mode_q      <= mode_d;
      stop_pend_q <= stop_pend_d;
      sig_q       <= sig_d;
      tick_q      <= tick_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign sig        = sig_q;
  assign count      = count_q;
  assign tick       = tick_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign burst_left = burst_q;

endmodule

// File: tb/tb_pwm_burst_gen.sv
// Scoreboard bench for pwm_burst_gen: stimulus queues expected outputs per cycle,
// a monitor pops and compares them shortly after each rising edge.
module tb_pwm_burst_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, start, stop, mode;
  logic [7:0] cfg_period, cfg_high, cfg_bursts;
  logic       sig, tick, busy, done;
  logic [7:0] count, burst_left;

  typedef struct packed {
    logic       sig;
    logic [7:0] cnt;
    logic       tick;
    logic       busy;
    logic       done;
    logic [7:0] bl;
  } obs_t;

  obs_t  cur;
  obs_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  assign cur = {sig, count, tick, busy, done, burst_left};

  pwm_burst_gen #(.CNT_W(8), .BURST_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .cfg_period(cfg_period),
    .cfg_high  (cfg_high),
    .cfg_bursts(cfg_bursts),
    .sig       (sig),
    .count     (count),
    .tick      (tick),
    .busy      (busy),
    .done      (done),
    .burst_left(burst_left)
  );

  always #5 clk = ~clk;

  function automatic void compare(input string nm, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got sig=%b count=%0d tick=%b busy=%b done=%b burst_left=%0d, expected sig=%b count=%0d tick=%b busy=%b done=%b burst_left=%0d",
               nm, act.sig, act.cnt, act.tick, act.busy, act.done, act.bl,
               exp.sig, exp.cnt, exp.tick, exp.busy, exp.done, exp.bl);
    end
  endfunction

  // Queue the expectation for the next rising edge, then advance to the next falling edge.
  task automatic cyc(input logic s, input int c, input logic t, input logic b, input logic d,
                     input int bl, input string nm);
    obs_t e;
    e = {s, 8'(c), t, b, d, 8'(bl)};
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  // Continuous run for n cycles, then a graceful stop and the done/idle cycles.
  task automatic run_check(input int per, input int high, input int n, input bit both,
                           input string nm);
    int  c;
    bit  pend;
    cfg_period = 8'(per);
    cfg_high   = 8'(high);
    mode       = 1'b0;
    en         = 1'b1;
    start      = 1'b1;
    stop       = both;
    for (int j = 0; j < n; j++) begin
      c = j % (per + 1);
      cyc(c < high, c, c == 0, 1'b1, 1'b0, 0, nm);
    end
    c    = (n - 1) % (per + 1);
    pend = 1'b0;
    stop = 1'b1;
    for (int k = 0; k < 600; k++) begin
      if (c == per) begin
        if (pend) break;
        c = 0;
      end else begin
        c++;
      end
      cyc(c < high, c, c == 0, 1'b1, 1'b0, 0, {nm, " stopping"});
      pend = 1'b1;
    end
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b1, 0, {nm, " done"});
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b0, 0, {nm, " idle"});
  endtask

  initial begin : monitor
    obs_t  e;
    string nm;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        compare(nm, cur, e);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no end, expected end");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    rst = 1'b1; en = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0;
    cfg_period = '0; cfg_high = '0; cfg_bursts = '0;
    @(negedge clk);
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b0, 0, "reset");
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b0, 0, "reset");
    rst = 1'b0;
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b0, 0, "idle after reset");

    // 4-cycle period, 2 high; stop issued at count=1
    run_check(3, 2, 14, 1'b0, "legacy");

    // Burst of three 5-cycle periods with one high cycle each
    cfg_period = 8'd4; cfg_high = 8'd1; cfg_bursts = 8'd3; mode = 1'b1; en = 1'b1;
    start = 1'b1;
    for (int j = 0; j < 15; j++)
      cyc((j % 5) == 0, j % 5, (j % 5) == 0, 1'b1, 1'b0, 3 - j / 5, "burst");
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b1, 0, "burst done");
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b0, 0, "burst idle");

    run_check(3, 0, 8, 1'b0, "high=0");
    run_check(3, 9, 8, 1'b0, "high>period");
    run_check(0, 1, 5, 1'b0, "period=0");
    run_check(1, 1, 4, 1'b1, "start+stop");

    // Burst with zero periods must not start
    cfg_period = 8'd3; cfg_bursts = 8'd0; mode = 1'b1; start = 1'b1;
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b0, 0, "zero bursts");
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b0, 0, "zero bursts");

    // Pause at count=1, then change high time mid-period
    cfg_period = 8'd3; cfg_high = 8'd2; mode = 1'b0; en = 1'b1; start = 1'b1;
    cyc(1'b1, 0, 1'b1, 1'b1, 1'b0, 0, "pause");
    cyc(1'b1, 1, 1'b0, 1'b1, 1'b0, 0, "pause");
    en = 1'b0;
    for (int j = 0; j < 3; j++) cyc(1'b1, 1, 1'b0, 1'b1, 1'b0, 0, "paused");
    en = 1'b1;
    cyc(1'b0, 2, 1'b0, 1'b1, 1'b0, 0, "resume");
    cyc(1'b0, 3, 1'b0, 1'b1, 1'b0, 0, "resume");
    cyc(1'b1, 0, 1'b1, 1'b1, 1'b0, 0, "resume");
    cfg_high = 8'd1;
    cyc(1'b1, 1, 1'b0, 1'b1, 1'b0, 0, "reconfig current");
    cyc(1'b0, 2, 1'b0, 1'b1, 1'b0, 0, "reconfig current");
    cyc(1'b0, 3, 1'b0, 1'b1, 1'b0, 0, "reconfig current");
    cyc(1'b1, 0, 1'b1, 1'b1, 1'b0, 0, "reconfig next");
    cyc(1'b0, 1, 1'b0, 1'b1, 1'b0, 0, "reconfig next");
    cyc(1'b0, 2, 1'b0, 1'b1, 1'b0, 0, "reconfig next");
    stop = 1'b1;
    cyc(1'b0, 3, 1'b0, 1'b1, 1'b0, 0, "reconfig stop");
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b1, 0, "reconfig done");

    // Asynchronous reset mid-period
    cfg_period = 8'd7; cfg_high = 8'd4; cfg_bursts = 8'd5; mode = 1'b1; start = 1'b1;
    cyc(1'b1, 0, 1'b1, 1'b1, 1'b0, 5, "pre-reset");
    cyc(1'b1, 1, 1'b0, 1'b1, 1'b0, 5, "pre-reset");
    cyc(1'b1, 2, 1'b0, 1'b1, 1'b0, 5, "pre-reset");
    #1 rst = 1'b1;
    #1 compare("async reset immediate", cur, '0);
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b0, 0, "in reset");
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b0, 0, "in reset");
    rst = 1'b0;
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b0, 0, "post reset idle");
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b0, 0, "post reset idle");
    run_check(1, 1, 3, 1'b0, "after reset");

    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
